// File: rtl/counter_pkg.sv
// Shared types and constants for the up/down counter family.
// Optional prescaler feature is selected with the COUNTER_PRESCALE_EN macro.
package counter_pkg;

    localparam int unsigned CNT_WIDTH_DEFAULT  = 3;
    localparam int unsigned CNT_MODULO_DEFAULT = 8;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } cnt_dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } cnt_mode_e;

    // Width of a counter that runs 0..prescale-1; never narrower than 1 bit.
    function automatic int unsigned prescale_width(input int unsigned prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable divider: asserts tick_o on every PRESCALE-th en_i cycle.
// Instantiated by param_updown_counter only when COUNTER_PRESCALE_EN is defined;
// also reusable as a baud-rate enable divider.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned     PW   = prescale_width(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    // Next prescaler value: clear wins, otherwise count enabled cycles and roll over on tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Prescaler register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Mod-MODULO up/down counter with enable, parallel load (clamped), wrap or
// saturate mode, registered terminal-count pulse and sticky overflow flag.
// Define COUNTER_PRESCALE_EN to divide the enable by PRESCALE before stepping.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = CNT_WIDTH_DEFAULT,
    parameter int unsigned MODULO   = CNT_MODULO_DEFAULT,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // An illegal parameter set freezes the counter instead of producing odd wraps.
    localparam logic PARAMS_OK = (WIDTH >= 2) && (WIDTH <= 16) &&
                                 (MODULO >= 2) && (MODULO <= (32'd1 << WIDTH)) &&
                                 (PRESCALE >= 1) && (PRESCALE <= 256);

    // Highest legal count, held one bit wider so MODULO == 2**WIDTH still fits.
    localparam logic [WIDTH:0] MAXV = (WIDTH + 1)'(MODULO - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             step;
    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   load_ext;
    cnt_dir_e         dir;
    cnt_mode_e        mode;

`ifdef COUNTER_PRESCALE_EN
    logic pre_tick;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (load),
        .en_i   (en),
        .tick_o (pre_tick)
    );

    assign step = pre_tick & PARAMS_OK;
`else
    assign step = en & PARAMS_OK;
`endif

    assign dir      = cnt_dir_e'(up);
    assign mode     = cnt_mode_e'(sat_mode);
    assign cnt_ext  = {1'b0, count_q};
    assign load_ext = {1'b0, load_val};

    // Next count and flags: load beats step; a boundary event raises tc and ovf.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q & ~clr_ovf;
        if (load) begin
            count_d = (load_ext > MAXV) ? WIDTH'(MAXV) : load_val;
        end else if (step) begin
            if (dir == DIR_UP) begin
                if (cnt_ext == MAXV) begin
                    count_d = (mode == MODE_SAT) ? count_q : '0;
                    tc_d    = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = WIDTH'(cnt_ext + 1'b1);
                end
            end else begin
                if (cnt_ext == '0) begin
                    count_d = (mode == MODE_SAT) ? count_q : WIDTH'(MAXV);
                    tc_d    = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = WIDTH'(cnt_ext - 1'b1);
                end
            end
        end
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench: three counter instances (mod 8, mod 6, mod 16) share
// one stimulus stream; a behavioural model is checked every cycle, plus
// directed sequences with literal expectations.
module tb_param_updown_counter;

    localparam int NI = 3;
`ifdef COUNTER_PRESCALE_EN
    localparam int PRE = 4;
`else
    localparam int PRE = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0, en = 1'b0, up = 1'b0, sat_mode = 1'b0;
    logic       load = 1'b0, clr_ovf = 1'b0;
    logic [3:0] load_val = '0;

    logic [2:0] count8, count6;
    logic [3:0] count16;
    logic       tc8, tc6, tc16, ovf8, ovf6, ovf16;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    int mods[NI] = '{8, 6, 16};
    int m_cnt[NI];
    int m_tc[NI];
    int m_ovf[NI];
    int m_pre;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(3), .MODULO(8), .PRESCALE(4)) dut8 (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat_mode(sat_mode), .load(load),
        .load_val(load_val[2:0]), .clr_ovf(clr_ovf), .count(count8), .tc(tc8), .ovf(ovf8));
    param_updown_counter #(.WIDTH(3), .MODULO(6), .PRESCALE(4)) dut6 (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat_mode(sat_mode), .load(load),
        .load_val(load_val[2:0]), .clr_ovf(clr_ovf), .count(count6), .tc(tc6), .ovf(ovf6));
    param_updown_counter #(.WIDTH(4), .MODULO(16), .PRESCALE(4)) dut16 (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat_mode(sat_mode), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf), .count(count16), .tc(tc16), .ovf(ovf16));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: state evolves from the counting rules directly.
    always @(posedge clk) begin
        int lv, old, step;
        bit boundary;
        if (rst) begin
            m_pre = 0;
            for (int i = 0; i < NI; i++) begin
                m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
            end
        end else if (load) begin
            m_pre = 0;
            for (int i = 0; i < NI; i++) begin
                lv = (i == 2) ? int'(load_val) : int'(load_val) % 8;
                m_cnt[i] = (lv < mods[i]) ? lv : mods[i] - 1;
                m_tc[i]  = 0;
                if (clr_ovf) m_ovf[i] = 0;
            end
        end else begin
            step = 0;
            if (en) begin
                m_pre = m_pre + 1;
                if (m_pre == PRE) begin
                    step  = 1;
                    m_pre = 0;
                end
            end
            for (int i = 0; i < NI; i++) begin
                old = m_cnt[i];
                boundary = 1'b0;
                if (step == 1) begin
                    if (up) begin
                        boundary = (old + 1 == mods[i]);
                        m_cnt[i] = (boundary && sat_mode) ? old : (old + 1) % mods[i];
                    end else begin
                        boundary = (old == 0);
                        m_cnt[i] = (boundary && sat_mode) ? old : (old + mods[i] - 1) % mods[i];
                    end
                end
                m_tc[i] = boundary ? 1 : 0;
                if (boundary) m_ovf[i] = 1;
                else if (clr_ovf) m_ovf[i] = 0;
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("model count8", int'(count8), m_cnt[0]);
            check("model tc8", int'(tc8), m_tc[0]);
            check("model ovf8", int'(ovf8), m_ovf[0]);
            check("model count6", int'(count6), m_cnt[1]);
            check("model tc6", int'(tc6), m_tc[1]);
            check("model ovf6", int'(ovf6), m_ovf[1]);
            check("model count16", int'(count16), m_cnt[2]);
            check("model tc16", int'(tc16), m_tc[2]);
            check("model ovf16", int'(ovf16), m_ovf[2]);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; en = 0; load = 0; clr_ovf = 0;
    endtask

    initial begin
        int exp_c[10];
        @(negedge clk);
        rst = 1;
        tick();
        rst = 0;
        chk_on = 1'b1;
        check("reset count", int'(count8), 0);
        check("reset tc", int'(tc8), 0);
        check("reset ovf", int'(ovf8), 0);

`ifndef COUNTER_PRESCALE_EN
        // Wrap up from reset.
        exp_c = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
        en = 1; up = 1; sat_mode = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("wrap count", int'(count8), exp_c[i]);
            check("wrap tc", int'(tc8), (i == 7) ? 1 : 0);
            check("wrap ovf", int'(ovf8), (i >= 7) ? 1 : 0);
        end
        // Down wrap on mod 6, then clamped load.
        idle(); load = 1; load_val = 4'd0;
        tick();
        check("load0 count6", int'(count6), 0);
        load = 0; en = 1; up = 0;
        tick();
        check("down count6", int'(count6), 5);
        check("down tc6", int'(tc6), 1);
        tick();
        check("down2 count6", int'(count6), 4);
        check("down2 tc6", int'(tc6), 0);
        idle(); load = 1; load_val = 4'd7;
        tick();
        check("clamp count6", int'(count6), 5);
        check("noclamp count8", int'(count8), 7);
        // Saturate at top.
        sat_mode = 1; load_val = 4'd6;
        tick();
        load = 0; en = 1; up = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("sat count", int'(count8), 7);
            check("sat tc", int'(tc8), (i == 0) ? 0 : 1);
        end
        // Load beats step.
        sat_mode = 0; load = 1; load_val = 4'd3;
        tick();
        check("prio count", int'(count8), 3);
        check("prio tc", int'(tc8), 0);
        // Set beats clear; then clear alone.
        idle(); load = 1; load_val = 4'd7;
        tick();
        idle(); en = 1; up = 1; clr_ovf = 1;
        tick();
        check("setclr count", int'(count8), 0);
        check("setclr ovf", int'(ovf8), 1);
        idle(); clr_ovf = 1;
        tick();
        check("clr ovf", int'(ovf8), 0);
        // Reset mid-count.
        idle(); load = 1; load_val = 4'd4;
        tick();
        idle(); en = 1; up = 1;
        tick();
        check("pre-rst count", int'(count8), 5);
        rst = 1;
        tick();
        check("midrst count", int'(count8), 0);
        check("midrst tc", int'(tc8), 0);
        check("midrst ovf", int'(ovf8), 0);
        rst = 0;
        tick();
        check("resume count", int'(count8), 1);
`else
        // Divide by four from reset.
        en = 1; up = 1; sat_mode = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("presc count", int'(count8), k / 4);
            check("presc tc", int'(tc8), 0);
        end
        // Load at cycle 6 restarts the divide.
        rst = 1;
        tick();
        rst = 0;
        for (int k = 1; k <= 10; k++) begin
            load = (k == 6);
            load_val = 4'd0;
            tick();
            if (k == 4) check("presc k4", int'(count8), 1);
            if (k == 6) check("presc load", int'(count8), 0);
            if (k == 9) check("presc k9", int'(count8), 0);
            if (k == 10) check("presc k10", int'(count8), 1);
        end
`endif

        // Random phase, checked by the model process.
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 99) == 0);
            load     = ($urandom_range(0, 7) == 0);
            load_val = 4'($urandom_range(0, 15));
            en       = ($urandom_range(0, 3) != 0);
            if (n % 40 == 0) up = $urandom_range(0, 1) == 1;
            if (n % 97 == 0) sat_mode = $urandom_range(0, 1) == 1;
            clr_ovf  = !load && ($urandom_range(0, 7) == 0);
            tick();
        end
        idle();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
